// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: state encoding, default widths, port indices.
package ram_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WR     = 3'd2,
        ST_RD     = 3'd3,
        ST_RD_CAP = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: combinational one-hot pick plus last-grant pointer.
// ARB_FIXED_PRIO_EN: port A always wins a tie and the pointer is dropped.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

`ifdef ARB_FIXED_PRIO_EN
    wire unused_ok = ^{clk, rst, upd};

    always_comb begin
        gnt = 2'b00;
        if (req[PORT_A])      gnt[PORT_A] = 1'b1;
        else if (req[PORT_B]) gnt[PORT_B] = 1'b1;
    end
`else
    logic last;  // port granted most recently; starts at B so A wins the first tie

    always_comb begin
        gnt = 2'b00;
        if (req[PORT_A] && (!req[PORT_B] || last == 1'(PORT_B))) gnt[PORT_A] = 1'b1;
        else if (req[PORT_B])                                    gnt[PORT_B] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'(PORT_B);
        else if (upd && |req)
            last <= gnt[PORT_B];
    end
`endif

endmodule

// File: rtl/ram_arb2.sv
// Serialises port A/B read/write requests onto a single-port synchronous RAM
// with a shared bidirectional data bus; the bus is driven only while writing.
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] rd_data,
    output logic          ram_ena,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data
);

    state_t        state;
    logic [1:0]    req, gnt;
    logic          upd;
    logic          sel;
    logic          wr_oe;
    logic [DW-1:0] wdata_q;

    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign req = {b_req, a_req};
    assign upd = (state == ST_IDLE) && |req;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .upd (upd),
        .gnt (gnt)
    );

    assign w_we    = gnt[PORT_B] ? b_we    : a_we;
    assign w_addr  = gnt[PORT_B] ? b_addr  : a_addr;
    assign w_wdata = gnt[PORT_B] ? b_wdata : a_wdata;

    assign ram_data = wr_oe ? wdata_q : {DW{1'bz}};

    // Every output is registered, so the RAM pins for a state are set on the edge entering it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            rd_data  <= '0;
            ram_ena  <= 1'b0;
            ram_wena <= 1'b0;
            ram_addr <= '0;
            wdata_q  <= '0;
            wr_oe    <= 1'b0;
            sel      <= 1'b0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                ST_INIT: begin
                    ram_ena  <= 1'b0;
                    ram_wena <= 1'b0;
                    wr_oe    <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (upd) begin
                        sel      <= gnt[PORT_B];
                        a_gnt    <= gnt[PORT_A];
                        b_gnt    <= gnt[PORT_B];
                        ram_ena  <= 1'b1;
                        ram_wena <= w_we;
                        ram_addr <= w_addr;
                        wdata_q  <= w_wdata;
                        wr_oe    <= w_we;
                        state    <= w_we ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    ram_ena  <= 1'b0;
                    ram_wena <= 1'b0;
                    wr_oe    <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_RD: begin
                    // dropping ena here makes the RAM release the bus after the capture cycle
                    ram_ena <= 1'b0;
                    state   <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    rd_data  <= ram_data;
                    a_rvalid <= (sel == 1'(PORT_A));
                    b_rvalid <= (sel == 1'(PORT_B));
                    state    <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb2.sv
// Bench for ram_arb2: behavioural RAM, transaction-level model compared every cycle,
// plus directed scenarios with literal expectations. Honours ARB_FIXED_PRIO_EN.
module tb_ram_arb2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] rd_data;
    logic        ram_ena, ram_wena;
    logic [4:0]  ram_addr;
    wire  [31:0] ram_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_arb2 dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rd_data(rd_data), .ram_ena(ram_ena), .ram_wena(ram_wena),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    // RAM: output register loads on a read edge and goes high-Z on any edge with ena=0
    logic [31:0] mem [32];
    logic [31:0] ram_q = '0;
    logic        ram_oe = 1'b0;
    assign ram_data = ram_oe ? ram_q : 32'bz;

    initial for (int i = 0; i < 32; i++) mem[i] = 32'(i);

    always @(posedge clk) begin
        if (ram_ena && ram_wena) mem[ram_addr] <= ram_data;
        if (ram_ena && !ram_wena) ram_q <= mem[ram_addr];
        ram_oe <= ram_ena && !ram_wena;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: busy = sampling edges still to skip; rvalid scheduled by cycle number
    logic [31:0] mmem [32];
    initial for (int i = 0; i < 32; i++) mmem[i] = 32'(i);
    int          busy = 1, cyc = 0, rv_at = -1;
    bit          last = 1'b1, rv_port = 1'b0;
    logic [31:0] rv_data = '0;
    logic        e_agnt = 0, e_bgnt = 0, e_arv = 0, e_brv = 0, e_ena = 0, e_wena = 0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_rd = '0;

    always @(negedge clk) begin
        bit w;
        if (rst) begin
            chk("rst_ctrl", {26'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ena, ram_wena}, 32'd0);
            chk("rst_addr", {27'd0, ram_addr}, 32'd0);
            chk("rst_rd_data", rd_data, 32'd0);
            busy = 1; last = 1'b1; rv_at = -1; cyc = 0;
            {e_agnt, e_bgnt, e_arv, e_brv, e_ena, e_wena} = '0;
            e_rd = '0;
        end else begin
            chk("a_gnt", {31'd0, a_gnt}, {31'd0, e_agnt});
            chk("b_gnt", {31'd0, b_gnt}, {31'd0, e_bgnt});
            chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, e_arv});
            chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, e_brv});
            chk("ram_ena", {31'd0, ram_ena}, {31'd0, e_ena});
            chk("ram_wena", {31'd0, ram_wena}, {31'd0, e_wena});
            if (e_ena) chk("ram_addr", {27'd0, ram_addr}, {27'd0, e_addr});
            chk("rd_data", rd_data, e_rd);
            if (ram_ena && ram_wena) chk("bus_released", {31'd0, ram_oe}, 32'd0);

            cyc++;
            {e_agnt, e_bgnt, e_arv, e_brv, e_ena, e_wena} = '0;
            if (busy == 0 && (a_req || b_req)) begin
`ifdef ARB_FIXED_PRIO_EN
                w = !a_req;
`else
                w = (a_req && b_req) ? !last : b_req;
`endif
                last   = w;
                e_agnt = !w;
                e_bgnt = w;
                e_ena  = 1'b1;
                e_wena = w ? b_we : a_we;
                e_addr = w ? b_addr : a_addr;
                if (e_wena) begin
                    mmem[e_addr] = w ? b_wdata : a_wdata;
                    busy = 1;
                end else begin
                    busy    = 2;
                    rv_at   = cyc + 2;
                    rv_port = w;
                    rv_data = mmem[e_addr];
                end
            end else if (busy > 0) begin
                busy--;
            end
            if (cyc == rv_at) begin
                e_arv = !rv_port;
                e_brv = rv_port;
                e_rd  = rv_data;
            end
        end
    end

    task automatic do_op(input bit p, input bit we, input logic [4:0] ad, input logic [31:0] d);
        bit got = 0;
        if (p) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = d; end
        else   begin a_req = 1; a_we = we; a_addr = ad; a_wdata = d; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = p ? b_gnt : a_gnt;
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
        a_req = 0; b_req = 0;
        if (we) begin
            @(posedge clk); #1;
        end else begin
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(posedge clk); #1;
                got = p ? b_rvalid : a_rvalid;
            end
            if (!got) chk("rvalid_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int          rvc;
        int          n;
        bit          got;
        string       order;
        logic [31:0] saved;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during a B read: the read's rvalid must never appear
        b_req = 1; b_we = 0; b_addr = 5'd5;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin @(posedge clk); #1; got = b_gnt; end
        chk("mid_rd_gnt", {31'd0, got}, 32'd1);
        b_req = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rvc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_rvalid || b_rvalid) rvc++;
        end
        chk("no_rvalid_after_rst", rvc, 32'd0);

        // A write: gnt one cycle after the sampling edge
        a_req = 1; a_we = 1; a_addr = 5'd3; a_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        chk("a_gnt_latency", {31'd0, a_gnt}, 32'd1);
        @(posedge clk); #1;
        a_req = 0;
        @(posedge clk); #1;
        chk("mem3", mem[3], 32'hDEADBEEF);

        // Read after write across ports
        do_op(0, 1, 5'd31, 32'h12345678);
        do_op(1, 0, 5'd31, 32'h0);
        chk("raw_rd_data", rd_data, 32'h12345678);

`ifdef ARB_FIXED_PRIO_EN
        a_we = 0; b_we = 0; a_addr = 5'd4; b_addr = 5'd5; a_req = 1; b_req = 1;
        order = ""; n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(posedge clk); #1;
            if (a_gnt) begin order = {order, "A"}; a_addr = a_addr + 5'd2; n++; end
            if (b_gnt) begin order = {order, "B"}; n++; end
        end
        a_req = 0;
        nvec++;
        if (order != "AAAA") begin
            nerr++;
            $display("FAIL fixed_order: got %s want AAAA", order);
        end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin @(posedge clk); #1; got = b_gnt; end
        chk("fixed_b_after_a_drop", {31'd0, got}, 32'd1);
        b_req = 0;
        repeat (4) @(posedge clk);
        #1;
`else
        a_we = 0; b_we = 0; a_addr = 5'd4; b_addr = 5'd5; a_req = 1; b_req = 1;
        order = ""; n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            @(posedge clk); #1;
            if (a_gnt) begin order = {order, "A"}; a_addr = a_addr + 5'd2; n++; end
            if (b_gnt) begin order = {order, "B"}; b_addr = b_addr + 5'd2; n++; end
        end
        a_req = 0; b_req = 0;
        nvec++;
        if (order != "ABABABAB") begin
            nerr++;
            $display("FAIL rr_order: got %s want ABABABAB", order);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("rr_last_rd_data", rd_data, 32'd11);
`endif

        // Turnaround: read then write the same address back to back
        do_op(0, 0, 5'd0, 32'h0);
        chk("turn_rd0", rd_data, 32'd0);
        do_op(0, 1, 5'd0, 32'hA5A5A5A5);
        do_op(1, 0, 5'd0, 32'h0);
        chk("turn_rd_back", rd_data, 32'hA5A5A5A5);
        chk("mem0", mem[0], 32'hA5A5A5A5);

        // Idle hold
        saved = rd_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_ena", {31'd0, ram_ena}, 32'd0);
        end
        chk("idle_rd_hold", rd_data, saved);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
